// File: rtl/point_array_stepper_if.sv
// Command / update-report bundle for point_array_stepper.
// master drives commands and observes reports; slave is the stepper.
interface point_array_stepper_if #(
    parameter int CHN = 4,
    parameter int W   = 8
);
    localparam int CW = (CHN > 1) ? $clog2(CHN) : 1;

    logic            cmd_vld;
    logic            cmd_rdy;
    logic [CW-1:0]   cmd_chn;
    logic [1:0]      cmd_op;
    logic [2*W-1:0]  cmd_pnt;
    logic            upd_vld;
    logic [CW-1:0]   upd_chn;
    logic [2*W-1:0]  upd_pnt;

    modport master (
        output cmd_vld, cmd_chn, cmd_op, cmd_pnt,
        input  cmd_rdy, upd_vld, upd_chn, upd_pnt
    );

    modport slave (
        input  cmd_vld, cmd_chn, cmd_op, cmd_pnt,
        output cmd_rdy, upd_vld, upd_chn, upd_pnt
    );
endinterface

// File: rtl/point_array_stepper.sv
// CHN packed {x,y} points; one command per cycle loads/steps/reads/inits.
// Ports: clk, rst (async low), bus (slave), pnt_o all points, ovf_o flags.
module point_array_stepper #(
    parameter int CHN = 4,
    parameter int W   = 8,
    parameter bit SAT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    point_array_stepper_if.slave  bus,
    output logic [CHN*2*W-1:0]    pnt_o,
    output logic [CHN-1:0]        ovf_o
);
    localparam int CW = (CHN > 1) ? $clog2(CHN) : 1;

    typedef enum logic [1:0] {
        OP_RD = 2'b00,
        OP_LD = 2'b01,
        OP_ST = 2'b10,
        OP_IN = 2'b11
    } op_t;

    logic [2*W-1:0] pnt [CHN];
    logic [CHN-1:0] ovf;
    logic           rdy;

    // stage E: one-deep command register
    logic           e_vld;
    logic [CW-1:0]  e_chn;
    op_t            e_op;
    logic [2*W-1:0] e_pnt;

    logic           u_vld;
    logic [CW-1:0]  u_chn;
    logic [2*W-1:0] u_pnt;

    logic           hit;
    logic [2*W-1:0] cur;
    logic [2*W-1:0] ini;
    logic           cur_ovf;
    logic [W:0]     ax;
    logic [W:0]     ay;
    logic [2*W-1:0] nxt;
    logic           nov;
    logic [2*W-1:0] res;

    // returns {out_of_range, result}
    function automatic logic [W:0] arith(
        input logic [W-1:0] a,
        input logic [W-1:0] d
    );
        logic [W+1:0] s;
        logic [W-1:0] r;
        s = {2'b00, a} + {{2{d[W-1]}}, d};
        r = s[W-1:0];
        if (SAT && s[W+1])
            r = '0;
        else if (SAT && s[W])
            r = '1;
        return {s[W+1] | s[W], r};
    endfunction

    always_comb begin
        hit     = 1'b0;
        cur     = '0;
        ini     = '0;
        cur_ovf = 1'b0;
        for (int c = 0; c < CHN; c++) begin
            if (e_chn == CW'(c)) begin
                hit     = 1'b1;
                cur     = pnt[c];
                ini     = (c % 2 == 1) ? '1 : '0;
                cur_ovf = ovf[c];
            end
        end
        ax  = arith(cur[2*W-1:W], e_pnt[2*W-1:W]);
        ay  = arith(cur[W-1:0], e_pnt[W-1:0]);
        nxt = cur;
        nov = cur_ovf;
        unique case (e_op)
            OP_RD: begin
                nxt = cur;
                nov = cur_ovf;
            end
            OP_LD: begin
                nxt = e_pnt;
                nov = 1'b0;
            end
            OP_ST: begin
                nxt = {ax[W-1:0], ay[W-1:0]};
                nov = cur_ovf | ax[W] | ay[W];
            end
            OP_IN: begin
                nxt = ini;
                nov = 1'b0;
            end
        endcase
        res = hit ? nxt : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy   <= 1'b0;
            e_vld <= 1'b0;
            e_chn <= '0;
            e_op  <= OP_RD;
            e_pnt <= '0;
            u_vld <= 1'b0;
            u_chn <= '0;
            u_pnt <= '0;
            ovf   <= '0;
            for (int c = 0; c < CHN; c++)
                pnt[c] <= (c % 2 == 1) ? '1 : '0;
        end else begin
            rdy   <= 1'b1;
            e_vld <= bus.cmd_vld && rdy;
            if (bus.cmd_vld && rdy) begin
                e_chn <= bus.cmd_chn;
                e_op  <= op_t'(bus.cmd_op);
                e_pnt <= bus.cmd_pnt;
            end
            u_vld <= e_vld;
            if (e_vld) begin
                u_chn <= e_chn;
                u_pnt <= res;
                for (int c = 0; c < CHN; c++) begin
                    if (e_chn == CW'(c)) begin
                        pnt[c] <= nxt;
                        ovf[c] <= nov;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < CHN; g++) begin : g_out
        assign pnt_o[g*2*W +: 2*W] = pnt[g];
    end

    assign ovf_o       = ovf;
    assign bus.cmd_rdy = rdy;
    assign bus.upd_vld = u_vld;
    assign bus.upd_chn = u_chn;
    assign bus.upd_pnt = u_pnt;
endmodule

// File: tb/tb_point_array_stepper.sv
// Scoreboard bench: one wrap-mode and one saturating stepper, CHN=4, W=8.
// Stimulus pushes expected reports; per-DUT monitors pop and compare.
module tb_point_array_stepper;
    logic clk;
    logic rst;

    point_array_stepper_if #(.CHN(4), .W(8)) ia ();
    point_array_stepper_if #(.CHN(4), .W(8)) ib ();

    logic [63:0] a_pnt;
    logic [3:0]  a_ovf;
    logic [63:0] b_pnt;
    logic [3:0]  b_ovf;

    point_array_stepper #(.CHN(4), .W(8), .SAT(1'b0)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .bus   (ia),
        .pnt_o (a_pnt),
        .ovf_o (a_ovf)
    );

    point_array_stepper #(.CHN(4), .W(8), .SAT(1'b1)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .bus   (ib),
        .pnt_o (b_pnt),
        .ovf_o (b_ovf)
    );

    typedef struct {
        logic [1:0]  chn;
        logic [15:0] pnt;
        logic        ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int passed = 0;
    int total  = 0;

    localparam logic [63:0] INIT = 64'hFFFF_0000_FFFF_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic send(input bit sel, input logic [1:0] chn,
                        input logic [1:0] op, input logic [15:0] p,
                        input logic [15:0] ep, input logic eo,
                        input bit push);
        exp_t e;
        e.chn = chn;
        e.pnt = ep;
        e.ovf = eo;
        if (!sel) begin
            ia.cmd_vld = 1'b1;
            ia.cmd_chn = chn;
            ia.cmd_op  = op;
            ia.cmd_pnt = p;
            if (push) qa.push_back(e);
        end else begin
            ib.cmd_vld = 1'b1;
            ib.cmd_chn = chn;
            ib.cmd_op  = op;
            ib.cmd_pnt = p;
            if (push) qb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ia.cmd_vld = 1'b0;
        ib.cmd_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && ia.upd_vld) begin
            if (qa.size() == 0) begin
                total++;
                $display("FAIL a_unexpected: got report ch%0d %0h, expected none",
                         ia.upd_chn, ia.upd_pnt);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_chn", 64'(ia.upd_chn), 64'(e.chn));
                check("a_pnt", 64'(ia.upd_pnt), 64'(e.pnt));
                check("a_slice", 64'(a_pnt[int'(e.chn)*16 +: 16]), 64'(e.pnt));
                check("a_ovf", 64'(a_ovf[e.chn]), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ib.upd_vld) begin
            if (qb.size() == 0) begin
                total++;
                $display("FAIL b_unexpected: got report ch%0d %0h, expected none",
                         ib.upd_chn, ib.upd_pnt);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_chn", 64'(ib.upd_chn), 64'(e.chn));
                check("b_pnt", 64'(ib.upd_pnt), 64'(e.pnt));
                check("b_slice", 64'(b_pnt[int'(e.chn)*16 +: 16]), 64'(e.pnt));
                check("b_ovf", 64'(b_ovf[e.chn]), 64'(e.ovf));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0;
        ia.cmd_vld = 1'b0;
        ia.cmd_chn = '0;
        ia.cmd_op  = '0;
        ia.cmd_pnt = '0;
        ib.cmd_vld = 1'b0;
        ib.cmd_chn = '0;
        ib.cmd_op  = '0;
        ib.cmd_pnt = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_a_pnt", a_pnt, INIT);
        check("rst_b_pnt", b_pnt, INIT);
        check("rst_a_rdy", 64'(ia.cmd_rdy), 64'd0);
        check("rst_a_ovf", 64'(a_ovf), 64'd0);
        check("rst_a_upd", 64'({ia.upd_vld, ia.upd_chn, ia.upd_pnt}), 64'd0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rdy_before_edge", 64'(ia.cmd_rdy), 64'd0);
        @(posedge clk);
        #1;
        check("rdy_after_edge_a", 64'(ia.cmd_rdy), 64'd1);
        check("rdy_after_edge_b", 64'(ib.cmd_rdy), 64'd1);

        // wrap mode: load then step ch2 back-to-back
        send(0, 2'd2, 2'b01, 16'h1020, 16'h1020, 1'b0, 1);
        send(0, 2'd2, 2'b10, 16'h01FF, 16'h111F, 1'b0, 1);
        // ch1 {FF,FF} + {+2,0} wraps x
        send(0, 2'd1, 2'b10, 16'h0200, 16'h01FF, 1'b1, 1);
        send(0, 2'd1, 2'b00, 16'h0000, 16'h01FF, 1'b1, 1);
        send(0, 2'd1, 2'b01, 16'hAA55, 16'hAA55, 1'b0, 1);
        idle(3);
        check("idle_upd_low", 64'(ia.upd_vld), 64'd0);

        // sustained stream: step ch0 interleaved with ch1 reads
        n = 0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] v;
            v = 8'(i + 1);
            send(0, 2'd0, 2'b10, 16'h0101, {v, v}, 1'b0, 1);
            if (n > 0) check("stream_upd_vld", 64'(ia.upd_vld), 64'd1);
            n++;
            send(0, 2'd1, 2'b00, 16'h0000, 16'hAA55, 1'b0, 1);
            check("stream_upd_vld", 64'(ia.upd_vld), 64'd1);
            n++;
        end
        idle(1);
        check("stream_tail_vld", 64'(ia.upd_vld), 64'd1);
        idle(2);
        check("stream_done_low", 64'(ia.upd_vld), 64'd0);

        // saturating mode
        send(1, 2'd0, 2'b10, 16'h807F, 16'h007F, 1'b1, 1);
        send(1, 2'd3, 2'b10, 16'h01FF, 16'hFFFE, 1'b1, 1);
        send(1, 2'd0, 2'b00, 16'h0000, 16'h007F, 1'b1, 1);
        send(1, 2'd3, 2'b11, 16'h1234, 16'hFFFF, 1'b0, 1);
        send(1, 2'd2, 2'b10, 16'hFF01, 16'h0001, 1'b1, 1);
        idle(4);

        // reset while a step sits in stage E
        send(0, 2'd2, 2'b10, 16'h0101, 16'h0000, 1'b0, 0);
        ia.cmd_vld = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_a_pnt", a_pnt, INIT);
        check("midrst_b_pnt", b_pnt, INIT);
        check("midrst_ovf", 64'({a_ovf, b_ovf}), 64'd0);
        check("midrst_upd", 64'(ia.upd_vld), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_a_pnt", a_pnt, INIT);
        check("post_rst_upd", 64'(ia.upd_vld), 64'd0);

        check("qa_empty", 64'(qa.size()), 64'd0);
        check("qb_empty", 64'(qb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
